// File: rtl/jbi_sc2_req_sched.sv
// JBI-to-L2 bank 2 request scheduler: round-robin read/write arbitration,
// header/data serialisation onto the 32-bit sctag request bus, IQ/WIB credit tracking.
module jbi_sc2_req_sched #(
    parameter int IQ_CREDITS  = 16,
    parameter int WIB_CREDITS = 4,
    parameter int WR_BEATS    = 16
) (
    input  logic        rclk,
    input  logic        rst,
    input  logic        rd_req_vld,
    input  logic [63:0] rd_req_hdr,
    output logic        rd_req_ack,
    input  logic        wr_req_vld,
    input  logic [63:0] wr_req_hdr,
    output logic        wr_req_ack,
    output logic        wr_data_rd,
    input  logic [31:0] wr_data,
    output logic [31:0] jbi_sctag_req,
    output logic        jbi_sctag_req_vld,
    input  logic        sctag_jbi_iq_dequeue,
    input  logic        sctag_jbi_wib_dequeue,
    output logic [4:0]  iq_credit_cnt,
    output logic [2:0]  wib_credit_cnt,
    output logic        credit_err
);

    typedef enum logic [1:0] {S_IDLE, S_H0, S_H1, S_DAT} state_t;

    localparam logic [4:0] LAST_BEAT = 5'(WR_BEATS - 1);
    localparam logic [4:0] IQ_MAX    = 5'(IQ_CREDITS);
    localparam logic [2:0] WIB_MAX   = 3'(WIB_CREDITS);

    state_t      r_state;
    logic        r_isWr;
    logic        r_lastWr;
    logic [4:0]  r_beatCnt;
    logic [63:0] r_hdr;
    logic [31:0] r_req;
    logic        r_reqVld;
    logic [4:0]  r_iqCnt;
    logic [2:0]  r_wibCnt;
    logic        r_creditErr;

    logic        w_lastBeat;
    logic        w_arbPt;
    logic        w_rdElig;
    logic        w_wrElig;
    logic        w_grantRd;
    logic        w_grantWr;
    logic        w_grant;
    logic [63:0] w_grantHdr;
    logic [4:0]  w_iqNext;
    logic [2:0]  w_wibNext;
    logic        w_iqOvf;
    logic        w_wibOvf;

    assign w_lastBeat = (r_beatCnt == LAST_BEAT);
    assign w_arbPt    = (r_state == S_IDLE) ||
                        (r_state == S_H1 && !r_isWr) ||
                        (r_state == S_DAT && w_lastBeat);

    // Eligibility looks at the pre-update counts, so a returned credit is usable one cycle later.
    assign w_rdElig   = rd_req_vld && (r_iqCnt != 5'd0);
    assign w_wrElig   = wr_req_vld && (r_iqCnt != 5'd0) && (r_wibCnt != 3'd0);
    assign w_grantRd  = w_arbPt && w_rdElig && (!w_wrElig || r_lastWr);
    assign w_grantWr  = w_arbPt && w_wrElig && (!w_rdElig || !r_lastWr);
    assign w_grant    = w_grantRd || w_grantWr;
    assign w_grantHdr = w_grantWr ? wr_req_hdr : rd_req_hdr;

    always_comb begin
        w_iqNext = r_iqCnt;
        w_iqOvf  = 1'b0;
        if (w_grant && !sctag_jbi_iq_dequeue) begin
            w_iqNext = r_iqCnt - 5'd1;
        end else if (!w_grant && sctag_jbi_iq_dequeue) begin
            if (r_iqCnt == IQ_MAX) w_iqOvf = 1'b1;
            else                   w_iqNext = r_iqCnt + 5'd1;
        end
    end

    always_comb begin
        w_wibNext = r_wibCnt;
        w_wibOvf  = 1'b0;
        if (w_grantWr && !sctag_jbi_wib_dequeue) begin
            w_wibNext = r_wibCnt - 3'd1;
        end else if (!w_grantWr && sctag_jbi_wib_dequeue) begin
            if (r_wibCnt == WIB_MAX) w_wibOvf = 1'b1;
            else                     w_wibNext = r_wibCnt + 3'd1;
        end
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_isWr      <= 1'b0;
            r_lastWr    <= 1'b1;
            r_beatCnt   <= 5'd0;
            r_hdr       <= 64'd0;
            r_req       <= 32'd0;
            r_reqVld    <= 1'b0;
            r_iqCnt     <= IQ_MAX;
            r_wibCnt    <= WIB_MAX;
            r_creditErr <= 1'b0;
        end else begin
            r_iqCnt     <= w_iqNext;
            r_wibCnt    <= w_wibNext;
            r_creditErr <= r_creditErr || w_iqOvf || w_wibOvf;
            if (w_arbPt) begin
                if (w_grant) begin
                    r_state  <= S_H0;
                    r_hdr    <= w_grantHdr;
                    r_isWr   <= w_grantWr;
                    r_lastWr <= w_grantWr;
                    r_req    <= w_grantHdr[63:32];
                    r_reqVld <= 1'b1;
                end else begin
                    r_state  <= S_IDLE;
                    r_req    <= 32'd0;
                    r_reqVld <= 1'b0;
                end
            end else begin
                // Non-arbitration H1 is always a write, so it falls into the data phase.
                case (r_state)
                    S_H0: begin
                        r_state  <= S_H1;
                        r_req    <= r_hdr[31:0];
                        r_reqVld <= 1'b0;
                    end
                    S_H1: begin
                        r_state   <= S_DAT;
                        r_beatCnt <= 5'd0;
                        r_req     <= wr_data;
                        r_reqVld  <= 1'b0;
                    end
                    S_DAT: begin
                        r_beatCnt <= r_beatCnt + 5'd1;
                        r_req     <= wr_data;
                        r_reqVld  <= 1'b0;
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_req    <= 32'd0;
                        r_reqVld <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rd_req_ack        = w_grantRd;
    assign wr_req_ack        = w_grantWr;
    assign wr_data_rd        = (r_state == S_H1 && r_isWr) || (r_state == S_DAT && !w_lastBeat);
    assign jbi_sctag_req     = r_req;
    assign jbi_sctag_req_vld = r_reqVld;
    assign iq_credit_cnt     = r_iqCnt;
    assign wib_credit_cnt    = r_wibCnt;
    assign credit_err        = r_creditErr;

endmodule

// File: tb/tb_jbi_sc2_req_sched.sv
// Self-checking bench for jbi_sc2_req_sched: scoreboard of expected bus beats
// plus directed checks on credits, arbitration order and reset behaviour.
module tb_jbi_sc2_req_sched;

    localparam int IQ_CREDITS  = 16;
    localparam int WIB_CREDITS = 4;
    localparam int WR_BEATS    = 16;

    logic        rclk = 1'b0;
    logic        rst  = 1'b1;
    logic        rd_req_vld;
    logic [63:0] rd_req_hdr;
    logic        rd_req_ack;
    logic        wr_req_vld;
    logic [63:0] wr_req_hdr;
    logic        wr_req_ack;
    logic        wr_data_rd;
    logic [31:0] wr_data;
    logic [31:0] jbi_sctag_req;
    logic        jbi_sctag_req_vld;
    logic        sctag_jbi_iq_dequeue  = 1'b0;
    logic        sctag_jbi_wib_dequeue = 1'b0;
    logic [4:0]  iq_credit_cnt;
    logic [2:0]  wib_credit_cnt;
    logic        credit_err;

    int checks   = 0;
    int failures = 0;

    int rdIssued = 0;
    int wrIssued = 0;
    int rdAcked  = 0;
    int wrAcked  = 0;
    int popIdx   = 0;
    int cycCnt   = 0;

    logic [32:0] sbQ[$];
    bit          grantKind[$];
    int          grantCyc[$];

    always #5 rclk = ~rclk;

    jbi_sc2_req_sched #(
        .IQ_CREDITS (IQ_CREDITS),
        .WIB_CREDITS(WIB_CREDITS),
        .WR_BEATS   (WR_BEATS)
    ) dut (
        .rclk                 (rclk),
        .rst                  (rst),
        .rd_req_vld           (rd_req_vld),
        .rd_req_hdr           (rd_req_hdr),
        .rd_req_ack           (rd_req_ack),
        .wr_req_vld           (wr_req_vld),
        .wr_req_hdr           (wr_req_hdr),
        .wr_req_ack           (wr_req_ack),
        .wr_data_rd           (wr_data_rd),
        .wr_data              (wr_data),
        .jbi_sctag_req        (jbi_sctag_req),
        .jbi_sctag_req_vld    (jbi_sctag_req_vld),
        .sctag_jbi_iq_dequeue (sctag_jbi_iq_dequeue),
        .sctag_jbi_wib_dequeue(sctag_jbi_wib_dequeue),
        .iq_credit_cnt        (iq_credit_cnt),
        .wib_credit_cnt       (wib_credit_cnt),
        .credit_err           (credit_err)
    );

    // Requesters hold vld until every issued request has been acked; headers advance per ack.
    assign rd_req_vld = (rdIssued != rdAcked);
    assign wr_req_vld = (wrIssued != wrAcked);
    assign rd_req_hdr = {32'hA5A5_0001 + 32'(rdAcked), 32'h0000_1040 + 32'(rdAcked)};
    assign wr_req_hdr = {32'hB7B7_0001 + 32'(wrAcked), 32'h0000_2080 + 32'(wrAcked)};
    assign wr_data    = 32'(popIdx);

    // Write-data FIFO model: head value is its pop index; also counts acks and cycles.
    always @(posedge rclk) begin
        cycCnt <= cycCnt + 1;
        if (rd_req_ack) rdAcked <= rdAcked + 1;
        if (wr_req_ack) wrAcked <= wrAcked + 1;
        if (wr_data_rd) popIdx  <= popIdx + 1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic sbMonitor();
        if (rst) begin
            sbQ.delete();
        end else begin
            if (sbQ.size() > 0)
                checkOutput("busBeat", {31'b0, jbi_sctag_req_vld, jbi_sctag_req}, {31'b0, sbQ.pop_front()});
            else
                checkOutput("busIdle", {31'b0, jbi_sctag_req_vld, jbi_sctag_req}, 64'h0);
            checkOutput("ackOneHot", 64'(rd_req_ack & wr_req_ack), 64'h0);
            if (rd_req_ack) begin
                sbQ.push_back({1'b1, rd_req_hdr[63:32]});
                sbQ.push_back({1'b0, rd_req_hdr[31:0]});
                grantKind.push_back(1'b0);
                grantCyc.push_back(cycCnt);
            end
            if (wr_req_ack) begin
                sbQ.push_back({1'b1, wr_req_hdr[63:32]});
                sbQ.push_back({1'b0, wr_req_hdr[31:0]});
                for (int k = 0; k < WR_BEATS; k++)
                    sbQ.push_back({1'b0, 32'(popIdx + k)});
                grantKind.push_back(1'b1);
                grantCyc.push_back(cycCnt);
            end
        end
    endtask

    task automatic nextCycle();
        @(negedge rclk);
        sbMonitor();
        @(posedge rclk);
        #1;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) nextCycle();
    endtask

    task automatic applyReset();
        rst = 1'b1;
        sctag_jbi_iq_dequeue  = 1'b0;
        sctag_jbi_wib_dequeue = 1'b0;
        runCycles(2);
        rst = 1'b0;
        grantKind.delete();
        grantCyc.delete();
    endtask

    task automatic applyStimulus(input int nRd, input int nWr);
        rdIssued += nRd;
        wrIssued += nWr;
    endtask

    initial begin
        int p0;
        int c;
        bit expKind[4];
        int expGap[3];
        expKind = '{1'b0, 1'b1, 1'b0, 1'b1};
        expGap  = '{2, 2 + WR_BEATS, 2};

        applyReset();
        checkOutput("rstReq",   64'(jbi_sctag_req), 64'h0);
        checkOutput("rstVld",   64'(jbi_sctag_req_vld), 64'h0);
        checkOutput("rstRdAck", 64'(rd_req_ack), 64'h0);
        checkOutput("rstWrAck", 64'(wr_req_ack), 64'h0);
        checkOutput("rstPop",   64'(wr_data_rd), 64'h0);
        checkOutput("rstIq",    64'(iq_credit_cnt), 64'(IQ_CREDITS));
        checkOutput("rstWib",   64'(wib_credit_cnt), 64'(WIB_CREDITS));
        checkOutput("rstErr",   64'(credit_err), 64'h0);

        // Single read
        applyStimulus(1, 0);
        nextCycle();
        checkOutput("rdBeat0", {31'b0, jbi_sctag_req_vld, jbi_sctag_req}, {31'b0, 1'b1, 32'hA5A50001});
        nextCycle();
        checkOutput("rdBeat1", {31'b0, jbi_sctag_req_vld, jbi_sctag_req}, {31'b0, 1'b0, 32'h00001040});
        runCycles(3);
        checkOutput("rdGrants", 64'(grantKind.size()), 64'd1);
        checkOutput("rdIq",     64'(iq_credit_cnt), 64'd15);

        // Single write
        applyReset();
        p0 = popIdx;
        applyStimulus(0, 1);
        runCycles(WR_BEATS + 6);
        checkOutput("wrGrants", 64'(grantKind.size()), 64'd1);
        checkOutput("wrPops",   64'(popIdx - p0), 64'(WR_BEATS));
        checkOutput("wrIq",     64'(iq_credit_cnt), 64'd15);
        checkOutput("wrWib",    64'(wib_credit_cnt), 64'd3);

        // Tie arbitration: R, W, R, W back to back
        applyReset();
        applyStimulus(2, 2);
        runCycles(2 * (2 + WR_BEATS) + 10);
        checkOutput("tieGrants", 64'(grantKind.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            checkOutput("tieKind", (i < grantKind.size()) ? 64'(grantKind[i]) : 64'hF, 64'(expKind[i]));
        for (int i = 0; i < 3; i++)
            checkOutput("tieGap", (i + 1 < grantCyc.size()) ? 64'(grantCyc[i + 1] - grantCyc[i]) : 64'hFFFF,
                        64'(expGap[i]));
        checkOutput("tieIq",  64'(iq_credit_cnt), 64'd12);
        checkOutput("tieWib", 64'(wib_credit_cnt), 64'd2);

        // WIB exhaustion: fifth write waits for a returned credit
        applyReset();
        applyStimulus(0, 5);
        runCycles(4 * (2 + WR_BEATS) + 10);
        checkOutput("wibGrants4", 64'(grantKind.size()), 64'd4);
        checkOutput("wibEmpty",   64'(wib_credit_cnt), 64'd0);
        checkOutput("wibIq",      64'(iq_credit_cnt), 64'd12);
        c = cycCnt;
        sctag_jbi_wib_dequeue = 1'b1;
        nextCycle();
        sctag_jbi_wib_dequeue = 1'b0;
        runCycles(3);
        checkOutput("wibGrants5", 64'(grantKind.size()), 64'd5);
        checkOutput("wibAckLat", (grantCyc.size() > 4) ? 64'(grantCyc[4] - c) : 64'hFFFF, 64'd1);
        checkOutput("wibAfter",   64'(wib_credit_cnt), 64'd0);
        runCycles(WR_BEATS + 4);
        checkOutput("wibIqEnd",   64'(iq_credit_cnt), 64'd11);

        // Simultaneous take and return, then overflow at the maximum
        applyReset();
        applyStimulus(1, 0);
        runCycles(4);
        checkOutput("trIq15", 64'(iq_credit_cnt), 64'd15);
        applyStimulus(1, 0);
        sctag_jbi_iq_dequeue = 1'b1;
        nextCycle();
        sctag_jbi_iq_dequeue = 1'b0;
        checkOutput("trNetZero", 64'(iq_credit_cnt), 64'd15);
        checkOutput("trGrants",  64'(grantKind.size()), 64'd2);
        runCycles(4);
        sctag_jbi_iq_dequeue = 1'b1;
        nextCycle();
        sctag_jbi_iq_dequeue = 1'b0;
        checkOutput("trIq16", 64'(iq_credit_cnt), 64'd16);
        checkOutput("trErr0", 64'(credit_err), 64'h0);
        sctag_jbi_iq_dequeue = 1'b1;
        nextCycle();
        sctag_jbi_iq_dequeue = 1'b0;
        checkOutput("ovfIqSat", 64'(iq_credit_cnt), 64'd16);
        checkOutput("ovfErr",   64'(credit_err), 64'h1);
        runCycles(3);
        checkOutput("ovfSticky", 64'(credit_err), 64'h1);
        applyReset();
        checkOutput("ovfRstClr", 64'(credit_err), 64'h0);

        // Reset in the middle of a write, at data beat 5
        p0 = popIdx;
        applyStimulus(0, 1);
        runCycles(8);
        checkOutput("midBeat5", {31'b0, jbi_sctag_req_vld, jbi_sctag_req}, {31'b0, 1'b0, 32'(p0 + 5)});
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        checkOutput("midReq", 64'(jbi_sctag_req), 64'h0);
        checkOutput("midVld", 64'(jbi_sctag_req_vld), 64'h0);
        checkOutput("midPop", 64'(wr_data_rd), 64'h0);
        checkOutput("midIq",  64'(iq_credit_cnt), 64'(IQ_CREDITS));
        checkOutput("midWib", 64'(wib_credit_cnt), 64'(WIB_CREDITS));
        runCycles(5);
        checkOutput("midPopTotal", 64'(popIdx - p0), 64'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
